// File: rtl/expr_sig_accum.sv
// expr_sig_accum: folds each accepted result vector into a 32-bit MISR
// signature. After a programmed number of vectors it compares the signature
// with an expected value and reports pass/fail.
module expr_sig_accum #(
  parameter int          Y_WIDTH   = 90,
  parameter int          CNT_WIDTH = 16,
  parameter logic [31:0] POLY      = 32'h04C11DB7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] num_vec,
  input  logic [31:0]          seed,
  input  logic [31:0]          exp_sig,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Y_WIDTH-1:0]   in_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 aborted,
  output logic [31:0]          sig,
  output logic [CNT_WIDTH-1:0] vec_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [31:0]          r_sig;
  logic [CNT_WIDTH-1:0] r_vec_cnt;
  logic [CNT_WIDTH-1:0] r_num_vec;
  logic [31:0]          r_exp_sig;
  logic                 r_done;
  logic                 r_pass;
  logic                 r_aborted;

  logic                 w_accept;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic [95:0]          w_y_pad;
  logic [31:0]          w_fold;
  logic [31:0]          w_sig_next;

  // Vectors narrower than 96 bits are zero-padded so the top chunk is
  // simply the remaining bits above bit 63.
  assign w_y_pad    = 96'(in_y);
  assign w_fold     = w_y_pad[31:0] ^ w_y_pad[63:32] ^ w_y_pad[95:64];
  assign w_sig_next = ({r_sig[30:0], 1'b0} ^ (r_sig[31] ? POLY : 32'h0)) ^ w_fold;

  assign in_ready  = (r_state == S_RUN);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_cnt_inc = r_vec_cnt + CNT_WIDTH'(1);

  assign sig     = r_sig;
  assign vec_cnt = r_vec_cnt;
  assign done    = r_done;
  assign pass    = r_pass;
  assign aborted = r_aborted;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: start in IDLE, vector countdown in RUN, abort exits.
  // NOTE: the default assignment first means every path drives the
  // next state, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = (num_vec == '0) ? S_CHECK : S_RUN;
      end
      S_RUN: begin
        if (abort)                                     w_state_next = S_IDLE;
        else if (w_accept && (w_cnt_inc == r_num_vec)) w_state_next = S_CHECK;
      end
      S_CHECK: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: run setup, MISR folding, final compare and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig     <= '0;
      r_vec_cnt <= '0;
      r_num_vec <= '0;
      r_exp_sig <= '0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sig     <= seed;
            r_vec_cnt <= '0;
            r_pass    <= 1'b0;
            r_aborted <= 1'b0;
            r_num_vec <= num_vec;
            r_exp_sig <= exp_sig;
          end
        end
        S_RUN: begin
          // Abort wins over a same-cycle accept; that vector is dropped.
          if (abort) begin
            r_aborted <= 1'b1;
            r_pass    <= 1'b0;
          end else if (w_accept) begin
            r_sig     <= w_sig_next;
            r_vec_cnt <= w_cnt_inc;
          end
        end
        S_CHECK: begin
          if (abort) begin
            r_aborted <= 1'b1;
            r_pass    <= 1'b0;
          end else begin
            r_pass <= (r_sig == r_exp_sig);
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_sig_accum.sv
// Randomized self-checking bench for expr_sig_accum with a behavioural
// signature model built from the fold/MISR arithmetic.
module tb_expr_sig_accum;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, in_valid;
  logic [15:0] num_vec;
  logic [31:0] seed, exp_sig;
  logic [89:0] in_y;
  logic        in_ready, busy, done, pass, aborted;
  logic [31:0] sig;
  logic [15:0] vec_cnt;

  int checks = 0;
  int errors = 0;

  expr_sig_accum dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_vec(num_vec), .seed(seed), .exp_sig(exp_sig),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
    .busy(busy), .done(done), .pass(pass), .aborted(aborted),
    .sig(sig), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: every input bit i lands on signature bit (i mod 32), then the
  // signature is multiplied by x modulo POLY before the fold is added.
  function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [89:0] y);
    logic [31:0] f = '0;
    logic [32:0] wide;
    for (int i = 0; i < 90; i++) if (y[i]) f[i % 32] = ~f[i % 32];
    wide = {s, 1'b0};
    if (wide[32]) wide[31:0] = wide[31:0] ^ POLY;
    return wide[31:0] ^ f;
  endfunction

  function automatic logic [89:0] rand_y();
    logic [95:0] t = {$urandom, $urandom, $urandom};
    return t[89:0];
  endfunction

  // Inputs change at negedge; outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One run: vpat bit k gives in_valid in RUN cycle k (mod 32) unless
  // rand_valid; abort_after >= 0 aborts once that many vectors are in.
  task automatic run(input string nm, input logic [15:0] n, input logic [31:0] sd,
                     input logic [31:0] ex, input bit use_fixed, input logic [89:0] fy,
                     input bit rand_valid, input logic [31:0] vpat,
                     input int abort_after, input bit abort_on_start);
    logic [31:0] m_sig = sd;
    int cnt = 0;
    int k = 0;
    start = 1'b1; abort = abort_on_start; num_vec = n; seed = sd; exp_sig = ex;
    tick();
    start = 1'b0; abort = 1'b0;
    check({nm, "_busy"}, 32'(busy), 32'd1);
    while (cnt < n) begin
      if (k > 300) begin
        check({nm, "_budget"}, cnt, 32'(n));
        return;
      end
      check({nm, "_rdy"}, 32'(in_ready), 32'd1);
      in_y     = use_fixed ? fy : rand_y();
      in_valid = rand_valid ? ($urandom_range(0, 2) != 0) : vpat[k % 32];
      // Stray start with new parameters while busy must be ignored.
      start    = ($urandom_range(0, 3) == 0);
      num_vec  = 16'($urandom); seed = $urandom; exp_sig = $urandom;
      if (cnt == abort_after) begin
        abort = 1'b1; in_valid = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0; start = 1'b0;
        check({nm, "_ab_busy"}, 32'(busy), 32'd0);
        check({nm, "_ab_flag"}, 32'(aborted), 32'd1);
        check({nm, "_ab_pass"}, 32'(pass), 32'd0);
        check({nm, "_ab_done"}, 32'(done), 32'd0);
        check({nm, "_ab_sig"}, sig, m_sig);
        check({nm, "_ab_cnt"}, 32'(vec_cnt), cnt);
        tick();
        check({nm, "_ab_done2"}, 32'(done), 32'd0);
        return;
      end
      if (in_valid) begin
        m_sig = ref_misr(m_sig, in_y);
        cnt++;
      end
      tick();
      k++;
    end
    in_valid = 1'b0; start = 1'b0;
    // CHECK cycle.
    check({nm, "_chk_rdy"}, 32'(in_ready), 32'd0);
    check({nm, "_chk_done"}, 32'(done), 32'd0);
    check({nm, "_chk_busy"}, 32'(busy), 32'd1);
    tick();
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_pass"}, 32'(pass), 32'(m_sig == ex));
    check({nm, "_sig"}, sig, m_sig);
    check({nm, "_cnt"}, 32'(vec_cnt), 32'(n));
    check({nm, "_aborted"}, 32'(aborted), 32'd0);
    check({nm, "_idle"}, 32'(busy), 32'd0);
    tick();
    check({nm, "_done_once"}, 32'(done), 32'd0);
    check({nm, "_hold_sig"}, sig, m_sig);
    check({nm, "_hold_pass"}, 32'(pass), 32'(m_sig == ex));
  endtask

  initial begin
    logic [89:0] y;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    num_vec = '0; seed = '0; exp_sig = '0; in_y = '0;
    #12;
    check("rst_sig", sig, 32'h0);
    check("rst_cnt", 32'(vec_cnt), 32'h0);
    check("rst_flags", {27'h0, in_ready, busy, done, pass, aborted}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run("zero",   16'd1, 32'h0, 32'h0, 1'b1, 90'h0, 1'b0, 32'h1, -1, 1'b0);
    run("poly",   16'd1, 32'h80000000, 32'h04C11DB7, 1'b1, 90'h0, 1'b0, 32'h1, -1, 1'b0);
    run("polyf",  16'd1, 32'h80000000, 32'h0, 1'b1, 90'h0, 1'b0, 32'h1, -1, 1'b0);
    y = '0; y[64] = 1'b1;
    run("fold64", 16'd1, 32'h0, 32'h1, 1'b1, y, 1'b0, 32'h1, -1, 1'b0);
    y = '0; y[32] = 1'b1; y[0] = 1'b1;
    run("alias",  16'd1, 32'h0, 32'h0, 1'b1, y, 1'b0, 32'h1, -1, 1'b0);
    run("toggle", 16'd3, $urandom, $urandom, 1'b0, '0, 1'b0, 32'b101001, -1, 1'b0);
    run("empty",  16'd0, 32'h12345678, 32'h12345678, 1'b0, '0, 1'b0, 32'h0, -1, 1'b0);
    run("abort",  16'd5, $urandom, $urandom, 1'b0, '0, 1'b0, 32'hFFFFFFFF, 2, 1'b0);

    // Abort in IDLE is ignored: sticky flag stays set.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_flag", 32'(aborted), 32'd1);

    // Start with abort together in IDLE: start honoured, abort ignored.
    run("st_ab", 16'd2, $urandom, $urandom, 1'b0, '0, 1'b0, 32'hFFFFFFFF, -1, 1'b1);

    // Reset mid-run discards the run immediately.
    start = 1'b1; num_vec = 16'd5; seed = $urandom; exp_sig = '0;
    tick();
    start = 1'b0; in_valid = 1'b1; in_y = rand_y();
    tick();
    in_y = rand_y();
    tick();
    check("mid_cnt", 32'(vec_cnt), 32'd2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_sig", sig, 32'h0);
    check("mrst_cnt", 32'(vec_cnt), 32'h0);
    check("mrst_flags", {27'h0, in_ready, busy, done, pass, aborted}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mrst_nodone", 32'(done), 32'd0);

    run("fresh", 16'd4, $urandom, $urandom, 1'b0, '0, 1'b1, 32'h0, -1, 1'b0);

    // Randomized runs, some with matching expected signature.
    for (int r = 0; r < 12; r++) begin
      logic [15:0] n = 16'($urandom_range(0, 20));
      logic [31:0] sd = $urandom;
      int ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      if (ab >= int'(n)) ab = -1;
      run("rand", n, sd, (n == 0) ? sd : $urandom, 1'b0, '0, 1'b1, 32'h0, ab, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
